key_matrix_scanner: RTL and testbench

KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

---
 rtl/key_matrix_scanner_if.sv | 10 +
 rtl/key_matrix_scanner.sv | 126 ++++++++++++
 tb/tb_key_matrix_scanner.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/key_matrix_scanner_if.sv
// rtl/key_matrix_scanner_if.sv - key event handshake between the matrix scanner and its consumer
interface key_matrix_scanner_if;
   logic       keyValid;
   logic [3:0] keyCode;
   logic       keyDown;
   logic       keyAck;

   modport master (output keyValid, output keyCode, output keyDown, input keyAck);
   modport slave  (input keyValid, input keyCode, input keyDown, output keyAck);
endinterface

// File: rtl/key_matrix_scanner.sv
// rtl/key_matrix_scanner.sv - 4x3 key matrix scanner with frame debounce and press-event queue
module key_matrix_scanner #(
   parameter int SCAN_DIV       = 10000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                        CLK,
   input  logic                        RSTn,
   output logic [3:0]                  rowOut,
   input  logic [2:0]                  colIn,
   key_matrix_scanner_if.master        key
);

   localparam int PW = $clog2(SCAN_DIV + 2);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 2);
   localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

   typedef enum logic {EMPTY, VALID} state_t;

   state_t        state;
   logic [PW-1:0] prescaler;
   logic [1:0]    row;
   logic [8:0]    snapshot;
   logic [11:0]   prev_frame;
   logic [11:0]   debounced;
   logic [11:0]   pending;
   logic [CW-1:0] stable;
   logic          key_valid;
   logic [3:0]    key_code;
   logic          key_down;

   logic          tick;
   logic          frame_end;
   logic          deb_load;
   logic [11:0]   frame;
   logic [11:0]   pend_set;
   logic [11:0]   pend_clr;
   logic [CW-1:0] stable_nxt;
   logic [3:0]    low_idx;

   assign tick      = (prescaler == PRE_MAX);
   assign frame_end = tick && (row == 2'd3);
   // row 3 is never stored: it is taken straight from the pins on the frame-end tick
   assign frame     = {~colIn, snapshot};
   assign rowOut    = ~(4'b0001 << row);

   assign key.keyValid = key_valid;
   assign key.keyCode  = key_code;
   assign key.keyDown  = key_down;

   always_comb begin
      stable_nxt = '0;
      if (frame == prev_frame)
         stable_nxt = (stable >= CNT_MAX) ? CNT_MAX : stable + 1'b1;
   end

   assign deb_load = frame_end && (stable_nxt >= CNT_MAX);
   assign pend_set = deb_load ? (frame & ~debounced) : '0;

   always_comb begin
      low_idx = '0;
      for (int i = 11; i >= 0; i--)
         if (pending[i]) low_idx = 4'(i);
   end

   assign pend_clr = (state == EMPTY && |pending) ? (12'b1 << low_idx) : '0;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         prescaler  <= '0;
         row        <= '0;
         snapshot   <= '0;
         prev_frame <= '0;
         stable     <= '0;
         debounced  <= '0;
         key_down   <= 1'b0;
      end else begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
         if (tick) begin
            row <= row + 1'b1;
            case (row)
               2'd0:    snapshot[2:0] <= ~colIn;
               2'd1:    snapshot[5:3] <= ~colIn;
               2'd2:    snapshot[8:6] <= ~colIn;
               default: ;
            endcase
         end
         if (frame_end) begin
            stable     <= stable_nxt;
            prev_frame <= frame;
         end
         if (deb_load)
            debounced <= frame;
         key_down <= deb_load ? |frame : |debounced;
      end
   end

   // new presses and the bit being handed out are merged so neither update is lost
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= EMPTY;
         pending   <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
      end else begin
         pending <= (pending & ~pend_clr) | pend_set;
         case (state)
            EMPTY: begin
               if (|pending) begin
                  state     <= VALID;
                  key_valid <= 1'b1;
                  key_code  <= low_idx;
               end
            end
            VALID: begin
               if (key.keyAck) begin
                  state     <= EMPTY;
                  key_valid <= 1'b0;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb/tb_key_matrix_scanner.sv - scoreboard bench for key_matrix_scanner
module tb_key_matrix_scanner;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic [3:0]  rowOut;
   logic [2:0]  colIn;
   logic [11:0] pressed = '0;
   logic        prev_valid = 1'b0;
   logic [3:0]  exp_row;
   int          checks = 0;
   int          errors = 0;
   int          exp_q[$];

   key_matrix_scanner_if ki ();

   key_matrix_scanner #(.SCAN_DIV(3), .DEBOUNCE_SCANS(2)) dut (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .rowOut (rowOut),
      .colIn  (colIn),
      .key    (ki)
   );

   always #5 CLK = ~CLK;

   // switch matrix: a pressed key pulls its column low while its row is driven
   always_comb begin
      colIn = 3'b111;
      for (int r = 0; r < 4; r++)
         if (!rowOut[r])
            for (int c = 0; c < 3; c++)
               if (pressed[r*3+c]) colIn[c] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (RSTn && ki.keyValid && !prev_valid) begin
         if (exp_q.size() == 0) check("spurious_event", 32'(ki.keyValid), 32'd0);
         else check("event_code", 32'(ki.keyCode), 32'(exp_q.pop_front()));
      end
      prev_valid = ki.keyValid;
   end

   task automatic start_reset();
      @(negedge CLK);
      RSTn = 1'b0;
      #1;
   endtask

   task automatic release_reset();
      @(negedge CLK);
      RSTn = 1'b1;
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && !ki.keyValid; i++) @(negedge CLK);
      check("valid_timeout", 32'(ki.keyValid), 32'd1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 32'(ki.keyValid), 32'd0);
      check({tag, "_down"}, 32'(ki.keyDown), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      ki.keyAck = 1'b0;
      start_reset();
      check("rst_row", 32'(rowOut), 32'hE);
      check("rst_code", 32'(ki.keyCode), 32'd0);
      check_idle("rst");

      // row walk, no keys
      release_reset();
      for (int k = 1; k <= 64; k++) begin
         @(negedge CLK);
         exp_row = ~(4'b0001 << ((k / 4) % 4));
         check("row_walk", 32'(rowOut), 32'(exp_row));
         if (k % 16 == 0) check_idle("walk");
      end

      // single press of key 4 held from reset
      start_reset();
      pressed = 12'h010;
      exp_q.push_back(4);
      release_reset();
      repeat (47) @(negedge CLK);
      check("single_down_early", 32'(ki.keyDown), 32'd0);
      @(negedge CLK);
      check("single_down", 32'(ki.keyDown), 32'd1);
      check("single_valid_early", 32'(ki.keyValid), 32'd0);
      @(negedge CLK);
      check("single_valid", 32'(ki.keyValid), 32'd1);
      check("single_code", 32'(ki.keyCode), 32'd4);
      ki.keyAck = 1'b1;
      @(negedge CLK);
      ki.keyAck = 1'b0;
      check("single_acked", 32'(ki.keyValid), 32'd0);
      repeat (64) @(negedge CLK);
      check("single_held_valid", 32'(ki.keyValid), 32'd0);
      check("single_held_down", 32'(ki.keyDown), 32'd1);
      pressed = '0;
      repeat (64) @(negedge CLK);
      check_idle("single_release");
      check("single_queue", 32'(exp_q.size()), 32'd0);

      // bounce on key 0: alternating frames
      start_reset();
      release_reset();
      for (int f = 0; f < 6; f++) begin
         pressed = (f % 2 == 0) ? 12'h001 : 12'h000;
         repeat (16) @(negedge CLK);
         check_idle("bounce");
      end
      pressed = '0;

      // keys 2 and 7 together, ack tied high
      start_reset();
      ki.keyAck = 1'b1;
      pressed = 12'h084;
      exp_q.push_back(2);
      exp_q.push_back(7);
      release_reset();
      wait_valid(100);
      check("multi_first", 32'(ki.keyCode), 32'd2);
      @(negedge CLK);
      check("multi_gap", 32'(ki.keyValid), 32'd0);
      @(negedge CLK);
      check("multi_second_valid", 32'(ki.keyValid), 32'd1);
      check("multi_second_code", 32'(ki.keyCode), 32'd7);
      @(negedge CLK);
      check("multi_end", 32'(ki.keyValid), 32'd0);
      pressed = '0;
      ki.keyAck = 1'b0;
      repeat (64) @(negedge CLK);
      check_idle("multi_release");
      check("multi_queue", 32'(exp_q.size()), 32'd0);

      // key 5 presented, released, never acked
      start_reset();
      pressed = 12'h020;
      exp_q.push_back(5);
      release_reset();
      wait_valid(100);
      check("unack_down", 32'(ki.keyDown), 32'd1);
      pressed = '0;
      for (int i = 0; i < 10; i++) begin
         repeat (10) @(negedge CLK);
         check("unack_valid", 32'(ki.keyValid), 32'd1);
         check("unack_code", 32'(ki.keyCode), 32'd5);
      end
      check("unack_down_fall", 32'(ki.keyDown), 32'd0);

      // reset in the middle of the handshake
      start_reset();
      check("mid_rst_row", 32'(rowOut), 32'hE);
      check("mid_rst_code", 32'(ki.keyCode), 32'd0);
      check_idle("mid_rst");
      release_reset();
      repeat (64) @(negedge CLK);
      check_idle("mid_rst_after");
      pressed = 12'h800;
      exp_q.push_back(11);
      wait_valid(100);
      ki.keyAck = 1'b1;
      @(negedge CLK);
      ki.keyAck = 1'b0;
      check("fresh_acked", 32'(ki.keyValid), 32'd0);
      pressed = '0;
      repeat (64) @(negedge CLK);
      check("final_queue", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
